// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side helpers: scanner FSM state encoding
// and the index-width helper.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;

  function automatic int idx_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/set_bit_scanner_prio_enc.sv
// Combinational priority encoder: mask -> {found, idx}.
// SET_BIT_SCANNER_MSB_FIRST_EN selects highest-bit priority; default is lowest-bit.
module prio_enc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Later loop iterations overwrite earlier ones, so the scan direction sets priority.
  always_comb begin
    found = |mask;
    idx   = '0;
`ifdef SET_BIT_SCANNER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
`endif
  end

endmodule

// File: rtl/set_bit_scanner.sv
// Serialises the set-bit indices of a WIDTH-bit mask, one index per beat.
// Build option SET_BIT_SCANNER_MSB_FIRST_EN emits indices highest-first.
module set_bit_scanner
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx,
  output logic             out_last,
  output logic             out_zero
);

  logic [1:0]       state;
  logic [WIDTH-1:0] mask;
  logic             enc_found;
  logic [IDX_W-1:0] enc_idx;
  logic             single_bit;
  logic [WIDTH-1:0] idx_onehot;

  prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_prio_enc (
    .mask  (mask),
    .found (enc_found),
    .idx   (enc_idx)
  );

  assign single_bit = ((mask & (mask - WIDTH'(1))) == '0);
  assign idx_onehot = WIDTH'(1) << enc_idx;

  // Outputs decode registered state only; rst gates in_ready so nothing is accepted during reset.
  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_SCAN) || (state == ST_ZERO);
    out_zero  = (state == ST_ZERO);
    if (state == ST_SCAN) begin
      idx      = enc_idx;
      out_last = single_bit && enc_found;
    end else if (state == ST_ZERO) begin
      idx      = '0;
      out_last = 1'b1;
    end else begin
      idx      = '0;
      out_last = 1'b0;
    end
  end

  // Scan FSM and mask register; each accepted beat clears its own bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mask  <= A;
            state <= (|A) ? ST_SCAN : ST_ZERO;
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            mask <= mask & ~idx_onehot;
            if (out_last) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_ZERO: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          mask  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// Self-checking bench for set_bit_scanner: directed and random masks against
// an index-list reference model, with varied backpressure and a mid-scan reset.
module tb_set_bit_scanner;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  localparam int BUDGET = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] idx;
  logic             out_last;
  logic             out_zero;

  int checks = 0;
  int failures = 0;

  set_bit_scanner #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .out_last  (out_last),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions in emission order, or a single 0 for an empty mask.
  task automatic build_expected(input logic [31:0] a, output int q[$]);
    q = {};
    for (int b = 0; b < WIDTH; b++) begin
      if (((a >> b) & 32'd1) == 32'd1) begin
`ifdef SET_BIT_SCANNER_MSB_FIRST_EN
        q.push_front(b);
`else
        q.push_back(b);
`endif
      end
    end
    if (q.size() == 0) q.push_back(0);
  endtask

  // mode 0: always ready; 1: toggle starting low; 2: random.
  task automatic run_mask(input logic [31:0] a, input int mode, input bit hold);
    int  exp_q[$];
    int  cyc;
    bit  tog;
    bit  r;
    bit  zero;
    zero = (a == 32'd0);
    build_expected(a, exp_q);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    A = a;
    @(negedge clk);
    if (!hold) begin
      in_valid = 1'b0;
      A = $urandom;
    end else begin
      A = $urandom;
    end
    cyc = 0;
    tog = 1'b0;
    while (exp_q.size() > 0 && cyc < BUDGET) begin
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_in_ready", {31'd0, in_ready}, 32'd0);
      chk("beat_idx", {27'd0, idx}, exp_q[0]);
      chk("beat_last", {31'd0, out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
      chk("beat_zero", {31'd0, out_zero}, {31'd0, zero});
      if (mode == 0) r = 1'b1;
      else if (mode == 1) begin r = tog; tog = ~tog; end
      else r = 1'($urandom_range(0, 1));
      out_ready = r;
      @(negedge clk);
      if (r) void'(exp_q.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (cyc >= BUDGET) begin
      checks++;
      failures++;
      $error("FAIL scan_timeout observed=%0d expected<%0d", cyc, BUDGET);
    end
    chk("done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int q0[$];
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_idx", {27'd0, idx}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_mask(32'h0000_0029, 0, 1'b0);
    run_mask(32'h0000_0000, 0, 1'b0);
    run_mask(32'h8000_0001, 1, 1'b0);
    run_mask(32'hFFFF_FFFF, 0, 1'b1);
    run_mask(32'h8000_0000, 2, 1'b0);
    run_mask(32'h0000_0000, 1, 1'b0);

    // Mid-scan reset after two beats of 0x0000F000.
    build_expected(32'h0000_F000, q0);
    in_valid = 1'b1;
    A = 32'h0000_F000;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mid_idx0", {27'd0, idx}, q0[0]);
    @(negedge clk);
    chk("mid_idx1", {27'd0, idx}, q0[1]);
    @(negedge clk);
    out_ready = 1'b0;
    chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_idx", {27'd0, idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    run_mask(32'h0000_0003, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      logic [31:0] m;
      m = $urandom;
      if (n % 4 == 1) m = m & $urandom & $urandom;
      run_mask(m, 2, n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
